// File: rtl/panel_input_if.sv
// panel_input_if: raw panel/sensor lines in, conditioned wash bus out
interface panel_input_if;
  logic start_btn;
  logic restart_btn;
  logic extra_rinse_btn;
  logic hot_btn;
  logic warm_btn;
  logic cold_btn;
  logic empty_raw;
  logic full_raw;
  logic [8:0] wash_bus;
  modport master(
    output start_btn, restart_btn, extra_rinse_btn, hot_btn, warm_btn, cold_btn, empty_raw, full_raw,
    input wash_bus
  );
  modport slave(
    input start_btn, restart_btn, extra_rinse_btn, hot_btn, warm_btn, cold_btn, empty_raw, full_raw,
    output wash_bus
  );
endinterface

// File: rtl/panel_input.sv
// panel_input: synchronise/debounce panel and level inputs, latch selections, generate timer tick
module panel_input #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV = 50
) (
  input logic clock,
  input logic resetn,
  panel_input_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TICK_DIV);
  // bit order: 0 empty, 1 full, 2 extra rinse, 3 hot, 4 warm, 5 cold, 6 restart, 7 start
  logic [7:0] raw, meta, sync, acc, prev, rise;
  logic run, start_p, restart_p, tick, xr, start_e, realign, wrap;
  logic [2:0] temp, temp_n;
  logic [1:0] lvl, lvl_q;
  logic [TW-1:0] tcnt;
  assign raw = {bus.start_btn, bus.restart_btn, bus.cold_btn, bus.warm_btn,
                bus.hot_btn, bus.extra_rinse_btn, bus.full_raw, bus.empty_raw};
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= acc;
    end
  for (genvar i = 0; i < 8; i++) begin : g_db
    logic a;
    logic [DW-1:0] c;
    always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
        a <= 1'b0;
        c <= '0;
      end else if (sync[i] == a) c <= '0;
      else if (c == DW'(DEBOUNCE_CYCLES - 1)) begin
        a <= sync[i];
        c <= '0;
      end else c <= c + 1'b1;
    assign acc[i] = a;
  end
  assign rise = acc & ~prev;
  // restart wins over a simultaneous start; start is ignored while running
  assign start_e = rise[7] & ~rise[6] & ~run;
  assign realign = start_e | rise[6];
  assign wrap = tcnt == TW'(TICK_DIV - 1);
  assign temp_n = run ? temp : rise[5] ? 3'b100 : rise[4] ? 3'b010 : rise[3] ? 3'b001 : temp;
  // a full+empty conflict holds the last consistent level
  assign lvl = &acc[1:0] ? lvl_q : acc[1:0];
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      run <= 1'b0;
      start_p <= 1'b0;
      restart_p <= 1'b0;
      tick <= 1'b0;
      xr <= 1'b0;
      temp <= 3'b010;
      lvl_q <= 2'b00;
      tcnt <= '0;
    end else begin
      start_p <= start_e;
      restart_p <= rise[6];
      run <= rise[6] ? 1'b0 : run | start_e;
      temp <= temp_n;
      xr <= xr ^ (rise[2] & ~run);
      lvl_q <= lvl;
      tcnt <= (realign | wrap) ? '0 : tcnt + 1'b1;
      tick <= wrap & ~realign;
    end
  assign bus.wash_bus = {start_p, restart_p, temp, xr, tick, lvl};
endmodule

// File: doc/panel_input.md
# panel_input

Front-panel and sensor conditioning stage for the washer controller. Synchronises and debounces the raw buttons, switches and tank level sensors. Latches the temperature and extra-rinse selections and generates the timer tick. Drives the 9-bit `wash_bus` that feeds the wash control block's `bus_in` directly.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive clock cycles an input must hold a new value before it is accepted (≥2).
- `TICK_DIV`, default 50: clock cycles per timer tick (≥2).

- `clock` in 1: system clock; all state on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start_btn` in 1: raw start push-button, active-high, asynchronous to `clock`.
- `restart_btn` in 1: raw restart push-button, active-high.
- `extra_rinse_btn` in 1: raw extra-rinse toggle button.
- `hot_btn`, `warm_btn`, `cold_btn` in 1 each: raw temperature select buttons.
- `empty_raw`, `full_raw` in 1 each: raw tank level sensors.
- `wash_bus` out 9: [0] empty, [1] full, [2] tick, [3] extra_rinse, [4] hot, [5] warm, [6] cold, [7] restart, [8] start.

## Operation
- Every raw input passes through a 2-flop synchroniser, then a per-input debouncer.
- Debouncer behaviour:
  - Holds an accepted value and a counter.
  - The counter clears whenever the synchronised value equals the accepted value.
  - Otherwise the counter increments.
  - When the synchronised value has differed for `DEBOUNCE_CYCLES` consecutive cycles, the accepted value flips and the counter clears.
- Edge detect on the accepted button values produces single-cycle rise events.
- start/restart:
  - `wash_bus[8]` and `wash_bus[7]` are registered one-cycle pulses, one per accepted rising edge.
  - If both rise in the same cycle, restart pulses and start is suppressed.
- Run flag:
  - Set by an emitted start pulse; cleared by a restart pulse.
  - Not visible on the bus.
  - A start rise while running is ignored: no pulse.
- Temperature:
  - One-hot register on [6:4], reset value warm (`3'b010`).
  - While idle, a rise event selects the corresponding temperature.
  - Simultaneous rises resolve by priority cold > warm > hot.
  - While running, rises are ignored and the selection is frozen.
  - The register is never zero and never multi-hot.
- Extra rinse:
  - Register on [3], reset 0.
  - Toggles on each rise event while idle; ignored while running.
- Level:
  - [0] and [1] carry the accepted empty/full values.
  - If both accepted values are 1 simultaneously (sensor fault), the outputs hold their last consistent value until the conflict clears.
- Tick divider:
  - Counter runs 0..`TICK_DIV`-1 and wraps.
  - `wash_bus[2]` pulses high for one cycle when the counter wraps to 0.
  - The counter is forced to 0, with no pulse, in the cycle a start or restart pulse is emitted, so that the first tick occurs exactly `TICK_DIV` cycles later.

## Timing
- Reset: asynchronous and immediate. `wash_bus` = `9'b0_0010_0000` (warm only). Run = 0; all counters, synchronisers and accepted values = 0.
- Releasing reset with a button held high:
  - The accepted value rises after debounce, so one rise event is generated.
  - This is intentional and is the first event after release.
- Button latency: raw rise stable before edge k gives the start/restart pulse (or temperature/extra-rinse update) visible after edge k+2+`DEBOUNCE_CYCLES`.
- Level latency: raw change to `wash_bus[1:0]` change takes 2+`DEBOUNCE_CYCLES` cycles.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles never reach the bus.
- Tick:
  - Period exactly `TICK_DIV` cycles in steady state; width 1 cycle.
  - Never coincides with a start or restart pulse.
- Temperature and extra-rinse changes take effect in the same cycle as their rise event is evaluated.
- A start pulse freezes the selection from the next edge. A rise in the same cycle as the start pulse is still accepted.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `TICK_DIV`=8.
- Reset check: assert `resetn`=0 mid-run → `wash_bus`=`0x020` immediately; after release, first tick appears 8 cycles later.
- Debounced start:
  - 3-cycle pulse on `start_btn` → no bus activity.
  - 10-cycle pulse → exactly one [8] pulse, 7 cycles after the raw rise.
  - The tick counter realigns: next [2] comes 8 cycles after the start pulse.
- Temperature select:
  - Idle, press `hot_btn` → [6:4]=`001`.
  - Press `cold_btn` and `hot_btn` together → [6:4]=`100`.
  - Start, then press `warm_btn` → [6:4] stays `100`.
- Extra rinse:
  - Two idle presses → [3] goes 1 then 0.
  - Press while running → no change.
  - After restart, press → [3]=1.
- Simultaneous start/restart: both raised in the same raw cycle → single [7] pulse, no [8] pulse; run stays 0, so a temperature press still takes effect.
- Level sensors:
  - `empty_raw`=1 → [0]=1 after 6 cycles.
  - Then raise `full_raw` with empty still 1 → [1:0] hold `01`.
  - Drop empty → [1:0]=`10` after the debounce period.
